// File: rtl/bf_stack.sv
// Register-file stack storage: 2**DEPTH x WIDTH entries, combinational read, clocked write.
// Define BF_STACK_WR_BYPASS_EN to forward wd onto rd when a write to the read address is pending.
module bf_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [DEPTH-1:0] ra,
  output logic [WIDTH-1:0] rd,
  input  logic             we,
  input  logic [DEPTH-1:0] wa,
  input  logic [WIDTH-1:0] wd
);

  localparam int unsigned ENTRIES = 2 ** DEPTH;

  logic [WIDTH-1:0] entry [ENTRIES];

  // Every entry is reset so no index ever reads X, used or not.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entry[i] <= '0;
      end
    end else if (we) begin
      entry[wa] <= wd;
    end
  end

`ifdef BF_STACK_WR_BYPASS_EN
  always_comb begin
    rd = entry[ra];
    if (we && (wa == ra)) begin
      rd = wd;
    end
  end
`else
  always_comb begin
    rd = entry[ra];
  end
`endif

endmodule

// File: tb/tb_bf_stack.sv
// Scoreboard bench for bf_stack: expected read data is queued when stimulus is driven
// and compared when rd is sampled; a local array models the storage.
`timescale 1ns/1ps
module tb_bf_stack;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned WIDTH   = 13;
  localparam int unsigned ENTRIES = 2 ** DEPTH;

  logic             clk;
  logic             resetq;
  logic [DEPTH-1:0] ra;
  logic [WIDTH-1:0] rd;
  logic             we;
  logic [DEPTH-1:0] wa;
  logic [WIDTH-1:0] wd;

  logic [WIDTH-1:0] model [ENTRIES];
  logic [WIDTH-1:0] sb [$];
  int unsigned      n_checks;
  int unsigned      n_fail;

  bf_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetq (resetq),
    .ra     (ra),
    .rd     (rd),
    .we     (we),
    .wa     (wa),
    .wd     (wd)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input string tag);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, sb.size(), 1);
    end else begin
      check(tag, {19'd0, rd}, {19'd0, sb.pop_front()});
    end
  endtask

  // Drive ra, queue the modelled content, sample 1ns later (no clock edge in between).
  task automatic read_chk(input logic [DEPTH-1:0] a, input string tag);
    ra = a;
    sb.push_back(model[a]);
    #1;
    sample(tag);
  endtask

  task automatic write(input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    we = 1'b1;
    wa = a;
    wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    model[a] = d;
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    logic [DEPTH-1:0] a;
    n_checks = 0;
    n_fail   = 0;
    resetq = 1'b0;
    we = 1'b0;
    ra = '0;
    wa = '0;
    wd = '0;
    for (int i = 0; i < ENTRIES; i++) model[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    read_chk(4'd0, "reset_e0");
    read_chk(4'd7, "reset_e7");
    read_chk(4'd15, "reset_e15");
    @(negedge clk);
    resetq = 1'b1;

    // Push/read
    ra = 4'd0;
    write(4'd1, 13'h0005);
    read_chk(4'd1, "push_e1");
    read_chk(4'd0, "push_e0_untouched");

    // Nested push/pop sweep
    write(4'd1, 13'h0010);
    write(4'd2, 13'h0020);
    write(4'd3, 13'h0030);
    read_chk(4'd3, "pop_e3");
    read_chk(4'd2, "pop_e2");
    read_chk(4'd1, "pop_e1");
    @(posedge clk);
    #1;
    read_chk(4'd3, "pop_e3_held");

    // Wrap boundary and full addressability
    write(4'd15, 13'h1FFF);
    write(4'd0, 13'h0001);
    read_chk(4'd15, "wrap_e15");
    read_chk(4'd0, "wrap_e0");
    for (int i = 0; i < ENTRIES; i++) write(i[DEPTH-1:0], 13'(i * 13'h0101 + 13'h0003));
    for (int i = 0; i < ENTRIES; i++) read_chk(i[DEPTH-1:0], $sformatf("addr_e%0d", i));

    // Same-address collision
    write(4'd4, 13'h0100);
    @(negedge clk);
    ra = 4'd4;
    wa = 4'd4;
    wd = 13'h0200;
    we = 1'b1;
`ifdef BF_STACK_WR_BYPASS_EN
    sb.push_back(13'h0200);
`else
    sb.push_back(13'h0100);
`endif
    #1;
    sample("collide_pre_edge");
    @(posedge clk);
    #1;
    we = 1'b0;
    model[4] = 13'h0200;
    read_chk(4'd4, "collide_post_edge");

    // Write disabled over 5 edges
    write(4'd6, 13'h0066);
    @(negedge clk);
    we = 1'b0;
    wa = 4'd6;
    wd = 13'h0777;
    repeat (5) @(posedge clk);
    #1;
    read_chk(4'd6, "we0_e6_hold");

    // Random writes against the model
    for (int n = 0; n < 20; n++) begin
      a = DEPTH'($urandom_range(ENTRIES - 1));
      v = WIDTH'($urandom);
      write(a, v);
      read_chk(DEPTH'($urandom_range(ENTRIES - 1)), "rand_rd");
    end

    // Asynchronous reset mid-cycle after filling with 0x1ABC
    for (int i = 0; i < ENTRIES; i++) write(i[DEPTH-1:0], 13'h1ABC);
    read_chk(4'd9, "fill_e9");
    @(negedge clk);
    #5;
    resetq = 1'b0;
    for (int i = 0; i < ENTRIES; i++) model[i] = '0;
    for (int i = 0; i < ENTRIES; i++) read_chk(i[DEPTH-1:0], $sformatf("async_rst_e%0d", i));

    // Write while reset low is lost
    @(negedge clk);
    we = 1'b1;
    wa = 4'd3;
    wd = 13'h0333;
    @(posedge clk);
    #1;
    we = 1'b0;
    read_chk(4'd3, "rst_low_write_lost");

    // First edge after release writes
    @(negedge clk);
    resetq = 1'b1;
    we = 1'b1;
    wa = 4'd2;
    wd = 13'h0222;
    @(posedge clk);
    #1;
    we = 1'b0;
    model[2] = 13'h0222;
    read_chk(4'd2, "first_edge_write");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_stack.md
BF_STACK -- requirements
Module: bf_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 4: address width in bits; storage holds 2**DEPTH entries.
REQ-002 SHALL have parameter WIDTH, default 13: data width of each entry in bits.
REQ-003 SHALL have port clk, input, 1 bit: clock; all writes occur on its rising edge.
REQ-004 SHALL have port resetq, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port ra, input, DEPTH bits: read address (caller's current top-of-stack pointer).
REQ-006 SHALL have port rd, output, WIDTH bits: read data at ra.
REQ-007 SHALL have port we, input, 1 bit: write enable.
REQ-008 SHALL have port wa, input, DEPTH bits: write address (caller's next pointer; independent of ra).
REQ-009 SHALL have port wd, input, WIDTH bits: write data.

Function
REQ-010 SHALL implement 2**DEPTH registers of WIDTH bits each; no internal pointer, the caller owns push/pop arithmetic.
REQ-011 SHALL drive rd combinationally from entry[ra]: a change on ra is visible on rd in the same cycle with no clock edge.
REQ-012 SHALL, on a rising clk edge with resetq high and we=1, write wd into entry[wa]; all other entries hold.
REQ-013 SHALL leave all entries unchanged on a rising edge with we=0; wa and wd are don't-care then.
REQ-014 SHALL, without bypass (see REQ-020), return the old content of entry[ra] while a write to wa==ra is pending; the new value appears on rd after the edge.
REQ-015 SHALL treat ra and wa as plain indices; pointer wrap-around (e.g. 2**DEPTH-1 -> 0) is the caller's concern, and every index 0..2**DEPTH-1 is valid with no overflow/underflow detection.
REQ-016 SHALL have no X-propagation from unused entries: every entry has a defined value from reset onward.

Reset
REQ-017 SHALL clear every entry to 0 immediately when resetq falls, independent of clk; rd then reads 0 for any ra.
REQ-018 SHALL ignore we while resetq is low; a write in the cycle resetq is low is lost.
REQ-019 SHALL accept writes from the first rising clk edge after resetq returns high.

Configuration
REQ-020 SHALL, when macro BF_STACK_WR_BYPASS_EN is defined, drive rd = wd whenever we=1 and wa==ra (combinational write-to-read forwarding); when undefined, rd always reflects stored content only (REQ-014).
REQ-021 SHALL keep port list, parameters and reset behaviour identical with and without BF_STACK_WR_BYPASS_EN.

Verification
REQ-022 Reset: write 0x1ABC to entries 0..15, assert resetq low mid-cycle -> rd reads 0 at every ra immediately, before any clk edge.
REQ-023 Push/read: ra=0, wa=1, we=1, wd=0x0005 for one edge, then ra=1 -> rd=0x0005; entry 0 still 0.
REQ-024 Nested push/pop: write 0x0010 @1, 0x0020 @2, 0x0030 @3; sweep ra 3,2,1 with we=0 -> rd 0x0030, 0x0020, 0x0010 combinationally, no entry altered.
REQ-025 Wrap: write 0x1FFF @15 and 0x0001 @0 -> ra=15 gives 0x1FFF, ra=0 gives 0x0001; all 16 entries independently addressable.
REQ-026 Same-address collision: entry 4=0x0100, ra=wa=4, we=1, wd=0x0200 -> before edge rd=0x0100 (macro undefined) or 0x0200 (BF_STACK_WR_BYPASS_EN defined); after edge rd=0x0200 in both builds.
REQ-027 Write disabled: we=0, wa=6, wd=0x0777 over 5 edges -> entry 6 keeps prior value.
